// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-to-pipeline-control bundle for pipeline_stall_ctrl.
// With HAZARD_STATS_EN defined the bundle also carries StallCount/FlushCount.
interface pipeline_stall_ctrl_if;
   // hazard requests from ID/EX
   logic LoadUse;
   logic Jump;
   logic BranchTaken;
   logic MdStart;
   logic MdDone;
   // pipeline register controls
   logic PCWrite;
   logic IFIDWrite;
   logic IFIDFlush;
   logic IDEXWrite;
   logic IDEXBubble;
   logic MdTimeout;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCount;
   logic [31:0] FlushCount;
`endif

   // hazard source / pipeline side
   modport master (
      output LoadUse, Jump, BranchTaken, MdStart, MdDone,
`ifdef HAZARD_STATS_EN
      input  StallCount, FlushCount,
`endif
      input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, MdTimeout
   );

   // stall controller side
   modport slave (
      input  LoadUse, Jump, BranchTaken, MdStart, MdDone,
`ifdef HAZARD_STATS_EN
      output StallCount, FlushCount,
`endif
      output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, MdTimeout
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: turns load-use, redirect and mul/div hazards into
// PC / IF/ID / ID/EX register controls (Mealy outputs, registered state).
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module pipeline_stall_ctrl #(
   parameter int unsigned LU_STALL_CYCLES = 1,
   parameter int unsigned MD_TIMEOUT      = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_stall_ctrl_if.slave hz
);

   localparam int unsigned LU_W = 4;
   localparam int unsigned MD_W = 8;
   localparam logic [LU_W-1:0] LU_INIT = LU_W'(LU_STALL_CYCLES - 1);
   localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MD_WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic [LU_W-1:0] lu_cnt;
   logic [MD_W-1:0] md_cnt;
   logic            md_timeout;

   logic pc_write_c;
   logic ifid_write_c;
   logic ifid_flush_c;
   logic idex_write_c;
   logic idex_bubble_c;

   // State and counter update; a pending load-use count survives a mul/div wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         lu_cnt     <= '0;
         md_cnt     <= '0;
         md_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hz.LoadUse) lu_cnt <= LU_INIT;
               if (hz.MdStart) begin
                  state  <= MD_WAIT;
                  md_cnt <= '0;
               end else if (hz.LoadUse && (LU_INIT != '0)) begin
                  state <= LU_STALL;
               end
            end
            LU_STALL: begin
               if (lu_cnt != '0) lu_cnt <= lu_cnt - LU_W'(1);
               if (lu_cnt <= LU_W'(1)) state <= RUN;
            end
            MD_WAIT: begin
               if (md_cnt != '1) md_cnt <= md_cnt + MD_W'(1);
               if (hz.MdDone || (md_cnt == MD_LAST)) begin
                  if (!hz.MdDone) md_timeout <= 1'b1;
                  state <= (lu_cnt != '0) ? LU_STALL : RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Mealy control outputs; reset holds the pipeline cleared.
   always_comb begin
      pc_write_c    = 1'b1;
      ifid_write_c  = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_write_c  = 1'b1;
      idex_bubble_c = 1'b0;
      if (reset) begin
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         ifid_flush_c  = 1'b1;
         idex_write_c  = 1'b0;
         idex_bubble_c = 1'b1;
      end else begin
         case (state)
            RUN: begin
               // load-use wins: the redirect used stale operands and is re-resolved later
               if (hz.LoadUse) begin
                  pc_write_c    = 1'b0;
                  ifid_write_c  = 1'b0;
                  idex_bubble_c = 1'b1;
               end else if (hz.Jump || hz.BranchTaken) begin
                  ifid_flush_c = 1'b1;
               end
            end
            LU_STALL: begin
               pc_write_c    = 1'b0;
               ifid_write_c  = 1'b0;
               idex_bubble_c = 1'b1;
            end
            MD_WAIT: begin
               pc_write_c   = 1'b0;
               ifid_write_c = 1'b0;
               idex_write_c = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign hz.PCWrite    = pc_write_c;
   assign hz.IFIDWrite  = ifid_write_c;
   assign hz.IFIDFlush  = ifid_flush_c;
   assign hz.IDEXWrite  = idex_write_c;
   assign hz.IDEXBubble = idex_bubble_c;
   assign hz.MdTimeout  = md_timeout;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   // Saturating counts of stalled and flushed cycles outside reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write_c && (stall_count != '1)) stall_count <= stall_count + 32'd1;
         if (ifid_flush_c && (flush_count != '1)) flush_count <= flush_count + 32'd1;
      end
   end

   assign hz.StallCount = stall_count;
   assign hz.FlushCount = flush_count;
`endif

endmodule
